// File: rtl/decode_ctrl_if.sv
// Fetch/decode boundary bundle for decode_ctrl: fetch drives pc/instr, decode
// returns stop plus the registered decoded fields and status flags.
interface decode_ctrl_if;
  logic [3:0] pc;
  logic [7:0] instr;
  logic       stop;
  logic       dec_valid;
  logic [3:0] dec_op;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic [3:0] dec_pc;
  logic       halted;
  logic       illegal;

  modport master (
    output pc, instr,
    input  stop, dec_valid, dec_op, dec_rd, dec_rs, dec_pc, halted, illegal
  );

  modport slave (
    input  pc, instr,
    output stop, dec_valid, dec_op, dec_rd, dec_rs, dec_pc, halted, illegal
  );
endinterface

// File: rtl/decode_ctrl.sv
// Decode/stall controller: registers decoded fields, stalls fetch on MUL, freezes on HALT.
// Optional feature macro: DECODE_ILLEGAL_TRAP_EN (trap opcodes 0xC-0xE into HALT).
module decode_ctrl #(
  parameter int unsigned MUL_CYCLES = 3
) (
  input logic         clk,
  input logic         reset,
  decode_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_MUL    = 4'h3;
  localparam logic [3:0] OP_HALT   = 4'hF;
  localparam bit         MUL_STALL = (MUL_CYCLES > 32'd1);
  localparam logic [2:0] STALL_LOAD = MUL_STALL ? 3'(MUL_CYCLES - 32'd2) : 3'd0;

  function automatic logic is_undef(input logic [3:0] op);
    is_undef = (op >= 4'hC) && (op <= 4'hE);
  endfunction

  state_t     state_r;
  logic [2:0] cnt_r;
  logic       stop_r;
  logic       dec_valid_r;
  logic [3:0] dec_op_r;
  logic [1:0] dec_rd_r;
  logic [1:0] dec_rs_r;
  logic [3:0] dec_pc_r;
  logic       halted_r;
  logic [3:0] op_s;

  assign op_s = bus.instr[7:4];

`ifdef DECODE_ILLEGAL_TRAP_EN
  logic illegal_r;

  // Sticky trap flag for undefined opcodes
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_r <= 1'b0;
    end else if (state_r == ST_RUN && is_undef(op_s)) begin
      illegal_r <= 1'b1;
    end else begin
      illegal_r <= illegal_r;
    end
  end

  assign bus.illegal = illegal_r;
`else
  assign bus.illegal = 1'b0;
`endif

  // Decode state machine with registered fetch-stall and decoded outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_RUN;
      cnt_r       <= 3'd0;
      stop_r      <= 1'b0;
      dec_valid_r <= 1'b0;
      dec_op_r    <= 4'h0;
      dec_rd_r    <= 2'd0;
      dec_rs_r    <= 2'd0;
      dec_pc_r    <= 4'h0;
      halted_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          dec_valid_r <= 1'b1;
          dec_rd_r    <= bus.instr[3:2];
          dec_rs_r    <= bus.instr[1:0];
          dec_pc_r    <= bus.pc;
          if (op_s == OP_HALT) begin
            dec_op_r <= op_s;
            stop_r   <= 1'b1;
            halted_r <= 1'b1;
            state_r  <= ST_HALT;
          end else if (is_undef(op_s)) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
            dec_op_r <= op_s;
            stop_r   <= 1'b1;
            halted_r <= 1'b1;
            state_r  <= ST_HALT;
`else
            // Undefined opcodes degrade to NOP; operand fields pass through raw
            dec_op_r <= 4'h0;
            stop_r   <= 1'b0;
            state_r  <= ST_RUN;
`endif
          end else if (op_s == OP_MUL && MUL_STALL) begin
            dec_op_r <= op_s;
            stop_r   <= 1'b1;
            cnt_r    <= STALL_LOAD;
            state_r  <= ST_STALL;
          end else begin
            dec_op_r <= op_s;
            stop_r   <= 1'b0;
            state_r  <= ST_RUN;
          end
        end
        ST_STALL: begin
          dec_valid_r <= 1'b0;
          if (cnt_r == 3'd0) begin
            stop_r  <= 1'b0;
            state_r <= ST_RUN;
          end else begin
            cnt_r   <= cnt_r - 3'd1;
            stop_r  <= 1'b1;
            state_r <= ST_STALL;
          end
        end
        ST_HALT: begin
          dec_valid_r <= 1'b0;
          stop_r      <= 1'b1;
          halted_r    <= 1'b1;
          state_r     <= ST_HALT;
        end
        default: begin
          state_r     <= ST_RUN;
          cnt_r       <= 3'd0;
          stop_r      <= 1'b0;
          dec_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stop      = stop_r;
  assign bus.dec_valid = dec_valid_r;
  assign bus.dec_op    = dec_op_r;
  assign bus.dec_rd    = dec_rd_r;
  assign bus.dec_rs    = dec_rs_r;
  assign bus.dec_pc    = dec_pc_r;
  assign bus.halted    = halted_r;

  decode_ctrl_chk u_chk (
    .clk     (clk),
    .reset   (reset),
    .stop    (stop_r),
    .halted  (halted_r),
    .illegal (bus.illegal)
  );

endmodule

// Invariants on the halt/stop status outputs
module decode_ctrl_chk (
  input logic clk,
  input logic reset,
  input logic stop,
  input logic halted,
  input logic illegal
);

  a_halt_holds_stop: assert property (@(posedge clk) disable iff (reset) halted |-> stop);
  a_halt_sticky:     assert property (@(posedge clk) disable iff (reset) halted |=> halted);
  a_illegal_halts:   assert property (@(posedge clk) disable iff (reset) illegal |-> halted);

endmodule

// File: tb/tb_decode_ctrl.sv
// Directed bench for decode_ctrl: two instances (MUL_CYCLES=3 and 1) fed by a
// small fetch model that advances pc whenever stop was low at the edge.
module tb_decode_ctrl;

  logic clk;
  logic reset;
  logic [7:0] rom [16];
  int vec_count_r;
  int miscompare_count_r;

  decode_ctrl_if if3 ();
  decode_ctrl_if if1 ();

  decode_ctrl #(.MUL_CYCLES(3)) u_dut3 (.clk(clk), .reset(reset), .bus(if3.slave));
  decode_ctrl #(.MUL_CYCLES(1)) u_dut1 (.clk(clk), .reset(reset), .bus(if1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_count_r++;
    if (obs !== exp) begin
      miscompare_count_r++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample stop before the edge, then advance the fetch model
  task automatic step();
    logic s3;
    logic s1;
    logic r;
    s3 = if3.stop;
    s1 = if1.stop;
    r  = reset;
    @(posedge clk);
    #1;
    if (r) begin
      if3.pc = 4'h0;
      if1.pc = 4'h0;
    end else begin
      if (!s3) if3.pc = if3.pc + 4'h1;
      if (!s1) if1.pc = if1.pc + 4'h1;
    end
    if3.instr = rom[if3.pc];
    if1.instr = rom[if1.pc];
  endtask

  task automatic fill_add();
    for (int i = 0; i < 16; i++) rom[i] = 8'h1B;
  endtask

  task automatic reset_pulse();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    vec_count_r = 0;
    miscompare_count_r = 0;
    reset = 1'b1;
    fill_add();
    if3.pc = 4'h0;
    if1.pc = 4'h0;
    if3.instr = rom[0];
    if1.instr = rom[0];

    // Reset state and 17 consecutive ADDs with pc wrap
    reset_pulse();
    check("rst_valid", 32'(if3.dec_valid), 32'd0);
    check("rst_stop", 32'(if3.stop), 32'd0);
    check("rst_halted", 32'(if3.halted), 32'd0);
    check("rst_illegal", 32'(if3.illegal), 32'd0);
    check("rst_op", 32'(if3.dec_op), 32'd0);
    check("rst_pc", 32'(if3.dec_pc), 32'd0);
    for (int k = 0; k < 17; k++) begin
      step();
      check("add_valid", 32'(if3.dec_valid), 32'd1);
      check("add_pc", 32'(if3.dec_pc), 32'(k % 16));
      check("add_op", 32'(if3.dec_op), 32'd1);
      check("add_rd", 32'(if3.dec_rd), 32'd2);
      check("add_rs", 32'(if3.dec_rs), 32'd3);
      check("add_stop", 32'(if3.stop), 32'd0);
    end

    // MUL at pc 2: three-cycle occupancy on u_dut3, none on u_dut1
    fill_add();
    rom[2] = 8'h36;
    reset_pulse();
    step();
    step();
    step();
    check("mul3_e0_op", 32'(if3.dec_op), 32'd3);
    check("mul3_e0_pc", 32'(if3.dec_pc), 32'd2);
    check("mul3_e0_valid", 32'(if3.dec_valid), 32'd1);
    check("mul3_e0_stop", 32'(if3.stop), 32'd1);
    check("mul1_e0_op", 32'(if1.dec_op), 32'd3);
    check("mul1_e0_stop", 32'(if1.stop), 32'd0);
    step();
    check("mul3_e1_valid", 32'(if3.dec_valid), 32'd0);
    check("mul3_e1_stop", 32'(if3.stop), 32'd1);
    check("mul3_e1_hold_pc", 32'(if3.dec_pc), 32'd2);
    check("mul3_e1_hold_op", 32'(if3.dec_op), 32'd3);
    check("mul1_e1_pc", 32'(if1.dec_pc), 32'd3);
    check("mul1_e1_valid", 32'(if1.dec_valid), 32'd1);
    step();
    check("mul3_e2_valid", 32'(if3.dec_valid), 32'd0);
    check("mul3_e2_stop", 32'(if3.stop), 32'd0);
    step();
    check("mul3_e3_valid", 32'(if3.dec_valid), 32'd1);
    check("mul3_e3_pc", 32'(if3.dec_pc), 32'd3);
    check("mul3_e3_op", 32'(if3.dec_op), 32'd1);
    check("mul3_e3_stop", 32'(if3.stop), 32'd0);

    // Reset in the middle of a MUL stall
    reset_pulse();
    step();
    step();
    step();
    step();
    check("mrst_pre_stop", 32'(if3.stop), 32'd1);
    reset_pulse();
    check("mrst_stop", 32'(if3.stop), 32'd0);
    check("mrst_valid", 32'(if3.dec_valid), 32'd0);
    check("mrst_op", 32'(if3.dec_op), 32'd0);
    check("mrst_pc", 32'(if3.dec_pc), 32'd0);
    check("mrst_rd", 32'(if3.dec_rd), 32'd0);
    step();
    check("mrst_cap_pc", 32'(if3.dec_pc), 32'd0);
    check("mrst_cap_valid", 32'(if3.dec_valid), 32'd1);
    step();
    check("mrst_cap_pc1", 32'(if3.dec_pc), 32'd1);

    // HALT at pc 5
    fill_add();
    rom[5] = 8'hF0;
    reset_pulse();
    for (int k = 0; k < 6; k++) step();
    check("halt_valid", 32'(if3.dec_valid), 32'd1);
    check("halt_op", 32'(if3.dec_op), 32'hF);
    check("halt_pc", 32'(if3.dec_pc), 32'd5);
    check("halt_stop", 32'(if3.stop), 32'd1);
    check("halt_halted", 32'(if3.halted), 32'd1);
    for (int k = 0; k < 22; k++) begin
      step();
      check("halt_hold_valid", 32'(if3.dec_valid), 32'd0);
      check("halt_hold_stop", 32'(if3.stop), 32'd1);
      check("halt_hold_halted", 32'(if3.halted), 32'd1);
      check("halt_hold_fetch", 32'(if3.pc), 32'd6);
      check("halt_hold_dpc", 32'(if3.dec_pc), 32'd5);
    end

    // Undefined opcode 0xD4 at pc 1
    fill_add();
    rom[1] = 8'hD4;
    reset_pulse();
    step();
    step();
    check("undef_valid", 32'(if3.dec_valid), 32'd1);
    check("undef_pc", 32'(if3.dec_pc), 32'd1);
    check("undef_rd", 32'(if3.dec_rd), 32'd1);
    check("undef_rs", 32'(if3.dec_rs), 32'd0);
`ifdef DECODE_ILLEGAL_TRAP_EN
    check("undef_op", 32'(if3.dec_op), 32'hD);
    check("undef_illegal", 32'(if3.illegal), 32'd1);
    check("undef_halted", 32'(if3.halted), 32'd1);
    check("undef_stop", 32'(if3.stop), 32'd1);
    step();
    check("undef_after_valid", 32'(if3.dec_valid), 32'd0);
    check("undef_after_stop", 32'(if3.stop), 32'd1);
`else
    check("undef_op", 32'(if3.dec_op), 32'h0);
    check("undef_illegal", 32'(if3.illegal), 32'd0);
    check("undef_halted", 32'(if3.halted), 32'd0);
    check("undef_stop", 32'(if3.stop), 32'd0);
    step();
    check("undef_after_valid", 32'(if3.dec_valid), 32'd1);
    check("undef_after_pc", 32'(if3.dec_pc), 32'd2);
    check("undef_after_op", 32'(if3.dec_op), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count_r, miscompare_count_r);
    $finish;
  end

endmodule

// File: doc/decode_ctrl.md
# decode_ctrl

Decode/stall controller that sits at the consuming end of the fetch stage's program counter. Each cycle it samples the 8-bit instruction read from instruction memory at the current `pc`, registers the decoded fields for the execute stage, and drives `stop` back to fetch. `stop` stalls fetch for multi-cycle MUL operations and freezes it permanently on HALT.

## Interface
- `MUL_CYCLES`, default 3: decode-slot occupancy of MUL in cycles; legal range 1..8; 1 means no stall.
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `pc`  in  4  current fetch PC; address of `instr`.
- `instr`  in  8  instruction-memory data at `pc`, combinational, valid every cycle.
- `stop`  out  1  registered; 1 holds fetch PC.
- `dec_valid`  out  1  1 for exactly one cycle per captured instruction.
- `dec_op`  out  4  captured `instr[7:4]`.
- `dec_rd`  out  2  captured `instr[3:2]`.
- `dec_rs`  out  2  captured `instr[1:0]`.
- `dec_pc`  out  4  `pc` value at capture.
- `halted`  out  1  1 once HALT is captured; sticky until reset.
- `illegal`  out  1  1 once an undefined opcode traps; sticky until reset; constant 0 without the macro.

## Operation
- Opcodes:
  - 0x0 NOP, 0x1 ADD, 0x2 SUB, 0x4 AND, 0x5 OR, 0x6 XOR, 0x7 MOV, 0x8–0xB reserved-legal: single-cycle.
  - 0x3 MUL: multi-cycle.
  - 0xC–0xE undefined.
  - 0xF HALT.
- States: RUN, STALL, HALT.
- RUN:
  - Captures `instr`/`pc` into `dec_*` and sets `dec_valid`=1.
  - MUL with `MUL_CYCLES`>1: `stop`<=1, stall counter <= `MUL_CYCLES`-2, go to STALL.
  - HALT: `stop`<=1, `halted`<=1, go to HALT.
  - Otherwise stays in RUN with `stop`=0.
- STALL:
  - `dec_valid`=0 and `instr` is ignored; `dec_op/rd/rs/pc` hold their last values.
  - Counter decrements each cycle.
  - Counter at 0: `stop`<=0, go to RUN.
- HALT: `dec_valid`=0, `stop`=1, `halted`=1; no exit except reset.
- MUL_CYCLES=1: MUL is handled exactly like a single-cycle op.
- PC wrap 15→0 needs no special handling; `dec_pc` reports 0 after 15.
- Counter width is 3 bits.

## Timing
- Reset (synchronous, active-high): at the first edge with `reset`=1:
  - all outputs become 0, state becomes RUN, counter becomes 0.
  - `reset` overrides every other condition, including mid-STALL and HALT.
- Capture latency: `dec_*` reflects the `instr`/`pc` sampled at the preceding edge, i.e. one cycle.
- Fetch advances `pc` on the same edge as a MUL/HALT capture, because `stop` was still 0. The next instruction (p+1) is therefore presented during the stall and captured on the first RUN edge.
- MUL at PC p, capture edge E0:
  - `stop`=1 after E0 for exactly `MUL_CYCLES`-1 cycles; falls after edge E(`MUL_CYCLES`-1).
  - Instruction p+1 is captured at edge E(`MUL_CYCLES`).
  - Total decode-slot occupancy = `MUL_CYCLES`.
- HALT at PC p: `dec_pc`=p and `dec_op`=0xF for one valid cycle. `stop` and `halted` go to 1 on the same edge. Fetch PC freezes at p+1.
- Back-to-back MULs: each incurs its full stall; there is no overlap.
- `stop` never glitches; it is a flop output.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN`:
  - Defined: opcodes 0xC–0xE are captured with `dec_valid`=1 and their raw `dec_op`. On the same edge `illegal`<=1, `halted`<=1, `stop`<=1, and the state goes to HALT.
  - Undefined: opcodes 0xC–0xE are captured as NOP (`dec_op`=0x0, `dec_rd`/`dec_rs` raw) and execution continues. `illegal` is tied to 0.

## Test plan
- Reset, then ROM of ADDs at pc 0..3:
  - `dec_valid`=1 every cycle; `dec_pc` = 0,1,2,3, one cycle behind `pc`.
  - `stop`=0 throughout.
- MUL at pc 2, `MUL_CYCLES`=3:
  - `dec_op`=3 with `dec_pc`=2.
  - `stop`=1 for exactly 2 cycles with `dec_valid`=0.
  - Next valid capture has `dec_pc`=3.
  - Repeat with `MUL_CYCLES`=1: no stall.
- HALT at pc 5:
  - One valid cycle with `dec_op`=0xF, `dec_pc`=5.
  - Then `stop`=`halted`=1 for 20+ cycles while `pc` stays 6.
- `reset` asserted for one cycle in the middle of a MUL stall:
  - At the next edge all outputs are 0 and `stop`=0.
  - Capture resumes from `pc`=0.
- Instruction 0xD4 at pc 1:
  - With the macro: `illegal`=`halted`=`stop`=1, `dec_op`=0xD.
  - Without the macro: `dec_op`=0x0, `dec_rd`=1, and execution continues.
- 17 consecutive ADDs: `dec_pc` runs 0..15 then 0, with `stop` never asserted.
